fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/tiny_cpu_pkg.sv | 19 +
 rtl/fetch_timeout_counter.sv | 36 +++
 rtl/fetch_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/tiny_cpu_pkg.sv
// Shared definitions for the tiny CPU front end: fetch FSM state encoding,
// bus widths and the default fetch timeout.
package tiny_cpu_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 16;

    // Default number of FETCH cycles tolerated without a memory ack.
    localparam int unsigned FETCH_TIMEOUT_DEFAULT = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_HOLD   = 3'd2,
        ST_HALTED = 3'd3,
        ST_ERROR  = 3'd4
    } fetch_state_t;

endpackage : tiny_cpu_pkg

// File: rtl/fetch_timeout_counter.sv
// Counts consecutive FETCH cycles and flags when the budget is used up.
// Only instantiated when FETCH_TIMEOUT_EN is defined.
//   clk_in, reset_in : clock, asynchronous active-high reset
//   clear            : forces the count to zero (held while not fetching)
//   enable           : count this cycle
//   expired          : this is the TIMEOUT_CYCLES-th enabled cycle since clear
module fetch_timeout_counter
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
)
(
    input  logic clk_in,
    input  logic reset_in,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = 8;

    logic [CNT_W-1:0] count_q;

    // Final allowed cycle: the count started at 0 on the first FETCH cycle.
    assign expired = enable && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

endmodule : fetch_timeout_counter

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: requests the word at pc_in, holds it for
// decode, and steers PC increment / branch load.
// Optional feature: define FETCH_TIMEOUT_EN to abort a fetch into an ERROR
// state after TIMEOUT_CYCLES cycles without mem_ack_in.
// Ports:
//   clk_in, reset_in                  clock, asynchronous active-high reset
//   pc_in                             current program counter
//   pc_update_en_out/_sel_out         PC strobe (sel 0 = +2, 1 = load jump)
//   jump_addr_out                     branch target for PC load
//   mem_req_out, mem_addr_out         fetch request and address
//   mem_ack_in, mem_rdata_in          fetch completion and data
//   instr_valid_out, instr_ready_in   handshake with decode
//   instr_out, instr_pc_out           held instruction and its address
//   branch_req_in, branch_target_in   redirect from decode
//   halt_in                           stop after current instruction
//   halted_out, fetch_err_out         status
module fetch_sequencer
    import tiny_cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = FETCH_TIMEOUT_DEFAULT
)
(
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_update_en_out,
    output logic              pc_update_sel_out,
    output logic [ADDR_W-1:0] jump_addr_out,
    output logic              mem_req_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    input  logic              mem_ack_in,
    input  logic [DATA_W-1:0] mem_rdata_in,
    output logic              instr_valid_out,
    input  logic              instr_ready_in,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc_out,
    input  logic              branch_req_in,
    input  logic [ADDR_W-1:0] branch_target_in,
    input  logic              halt_in,
    output logic              halted_out,
    output logic              fetch_err_out
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("fetch_sequencer: TIMEOUT_CYCLES must be in 2..255");
    end

    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic              capture;
    logic              timeout_expired;

`ifdef FETCH_TIMEOUT_EN
    // Counter sits at zero outside FETCH, so each FETCH entry starts fresh.
    fetch_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .clear    (state_q != ST_FETCH),
        .enable   (state_q == ST_FETCH),
        .expired  (timeout_expired)
    );
    assign fetch_err_out = (state_q == ST_ERROR);
`else
    assign timeout_expired = 1'b0;
    assign fetch_err_out   = 1'b0;
`endif

    // State and captured-instruction registers.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q    <= ST_IDLE;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                instr_q    <= mem_rdata_in;
                instr_pc_q <= pc_in;
            end
        end
    end

    // Next state and PC strobe; ack wins over a coincident timeout.
    always_comb begin
        state_d           = state_q;
        capture           = 1'b0;
        pc_update_en_out  = 1'b0;
        pc_update_sel_out = 1'b0;
        jump_addr_out     = '0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ack_in) begin
                    capture          = 1'b1;
                    pc_update_en_out = 1'b1;
                    state_d          = ST_HOLD;
                end else if (timeout_expired) begin
`ifdef FETCH_TIMEOUT_EN
                    state_d = ST_ERROR;
`else
                    state_d = ST_FETCH;
`endif
                end
            end
            ST_HOLD: begin
                if (instr_ready_in) begin
                    if (halt_in) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_FETCH;
                        if (branch_req_in) begin
                            pc_update_en_out  = 1'b1;
                            pc_update_sel_out = 1'b1;
                            jump_addr_out     = branch_target_in;
                        end
                    end
                end
            end
            default: begin
                // HALTED and ERROR are left only through reset.
                state_d = state_q;
            end
        endcase
    end

    // Status decoded from the state register so reset clears them at once.
    assign mem_req_out     = (state_q == ST_FETCH);
    assign mem_addr_out    = (state_q == ST_FETCH) ? pc_in : '0;
    assign instr_valid_out = (state_q == ST_HOLD);
    assign halted_out      = (state_q == ST_HALTED);
    assign instr_out       = instr_q;
    assign instr_pc_out    = instr_pc_q;

endmodule : fetch_sequencer
